reg_add_seq: RTL and testbench
==============================

REG_ADD_SEQ -- requirements
Module: reg_add_seq

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_ra  in  5  first source register.
- cmd_rb  in  5  second source register.
- cmd_rw  in  5  destination register.
- cmd_sub  in  1  1 = subtract, 0 = add; see Configuration.
- Ra  out  5  register bank read address A.
- Rb  out  5  register bank read address B.
- Rw  out  5  register bank write address.
- WE  out  1  register bank write enable.
- dIN  out  64  register bank write data.
- doutA  in  64  bank read data for Ra, combinational.
- doutB  in  64  bank read data for Rb, combinational.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- ovf  out  1  signed overflow of the last completed operation.

Function
REQ-002 The block SHALL be an FSM with states IDLE, READ, EXEC and WRITE.
REQ-003 cmd_ready SHALL be 1 only in IDLE; busy SHALL be 1 in READ, EXEC and WRITE.
REQ-004 A command SHALL be accepted on a rising edge with cmd_valid=1 and cmd_ready=1.
- On acceptance the block SHALL latch cmd_ra, cmd_rb, cmd_rw and cmd_sub into Ra, Rb, Rw and an internal op bit, and enter READ.
REQ-005 READ lasts one cycle. At its end the block SHALL capture doutA and doutB into 64-bit operand registers and enter EXEC.
REQ-006 EXEC lasts one cycle. At its end the block SHALL store the result and ovf, then enter WRITE.
- Result = opA+opB, or opA-opB when op=1, modulo 2^64; the carry is discarded.
- ovf = signed two's-complement overflow of that operation.
REQ-007 WRITE lasts one cycle. In it the block SHALL:
- drive WE=1 with dIN=result and Rw as latched;
- pulse done=1;
- then return to IDLE.
REQ-008 Latency SHALL be exactly 3 cycles from the acceptance edge to the edge that ends WRITE; back-to-back commands SHALL be accepted at most once every 4 cycles.
REQ-009 When Rw=31 (XZR), WE SHALL stay 0 in WRITE. done and ovf SHALL still update normally.
REQ-010 Source operands SHALL equal the bank contents at READ, including when Ra=Rb or when Rw equals a source.
REQ-011 Ra, Rb, Rw, dIN and ovf SHALL hold their values outside the cycles that update them.
REQ-012 cmd_* inputs SHALL be ignored while cmd_ready=0; a held cmd_valid SHALL be accepted on the first IDLE edge.
REQ-013 WE SHALL never be 1 outside WRITE.

Reset
REQ-014 While rst_n=0, independent of clk, the block SHALL force:
- state IDLE;
- Ra=Rb=Rw=0 and dIN=0;
- WE=0, done=0, busy=0, ovf=0 and cmd_ready=0.
REQ-015 Reset asserted in any state SHALL abort the command in flight with no bank write.
- If WRITE is interrupted, WE SHALL drop immediately.
REQ-016 cmd_ready SHALL rise in the first cycle after rst_n deasserts.

Configuration
REQ-017 With macro REG_ADD_SEQ_SUB_EN defined, cmd_sub SHALL select subtraction as in REQ-006.
REQ-018 Without REG_ADD_SEQ_SUB_EN, cmd_sub SHALL be ignored: every command adds, and ovf reflects addition only.

Verification
REQ-019 The bench SHALL cover these scenarios:
- Bank X1=5, X2=7; command ra=1, rb=2, rw=3, add -> WE=1 with Rw=3 and dIN=12 exactly 3 cycles after acceptance; done pulses once; ovf=0.
- X1=0x7FFFFFFFFFFFFFFF, X2=1, add into rw=4 -> dIN=0x8000000000000000 and ovf=1. X1=0xFFFFFFFFFFFFFFFF, X2=1 -> dIN=0 and ovf=0.
- With SUB_EN, X1=3, X2=5, sub -> dIN=0xFFFFFFFFFFFFFFFE and ovf=0. Without SUB_EN, the same command -> dIN=8.
- rw=31 -> WE stays 0 for the whole command, done=1 in WRITE, and the bank is unchanged.
- cmd_valid held high for 10 cycles -> accepted on cycles 0, 4 and 8 only; cmd_ready low in between.
- rst_n pulled low during EXEC, and separately during WRITE -> WE=0 and busy=0 at once; bank unchanged; cmd_ready=1 the cycle after release.

Source files
------------

// File: rtl/reg_add_seq.sv
// Register-bank add/sub sequencer (READ -> EXEC -> WRITE); REG_ADD_SEQ_SUB_EN enables subtraction.
// Latency is 3 cycles from acceptance to the end of WRITE; cmd_ready is high only in IDLE, so at most one command every 4 cycles.
module reg_add_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_ra,
  input  logic [4:0]  cmd_rb,
  input  logic [4:0]  cmd_rw,
  input  logic        cmd_sub,
  output logic [4:0]  Ra,
  output logic [4:0]  Rb,
  output logic [4:0]  Rw,
  output logic        WE,
  output logic [63:0] dIN,
  input  logic [63:0] doutA,
  input  logic [63:0] doutB,
  output logic        busy,
  output logic        done,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  state_t      state_q, state_d;
  logic        accept;
  logic        op_sub;
  logic [63:0] op_a_q, op_b_q;
  logic [63:0] result;
  logic        result_ovf;

`ifdef REG_ADD_SEQ_SUB_EN
  logic op_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= 1'b0;
    end else if (accept) begin
      op_q <= cmd_sub;
    end
  end

  assign op_sub = op_q;
`else
  logic unused_cmd_sub;

  assign unused_cmd_sub = cmd_sub;
  assign op_sub         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // cmd_ready is gated by rst_n because the state register already reads IDLE while reset is held.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    WE        = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = rst_n;
        accept    = cmd_valid & rst_n;
        if (accept) state_d = READ;
      end
      READ: begin
        busy    = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        busy    = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        busy    = 1'b1;
        done    = 1'b1;
        WE      = (Rw != 5'd31);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    result = op_sub ? (op_a_q - op_b_q) : (op_a_q + op_b_q);
    if (op_sub) begin
      result_ovf = (op_a_q[63] != op_b_q[63]) && (result[63] != op_a_q[63]);
    end else begin
      result_ovf = (op_a_q[63] == op_b_q[63]) && (result[63] != op_a_q[63]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Ra     <= 5'd0;
      Rb     <= 5'd0;
      Rw     <= 5'd0;
      op_a_q <= 64'd0;
      op_b_q <= 64'd0;
      dIN    <= 64'd0;
      ovf    <= 1'b0;
    end else begin
      if (accept) begin
        Ra <= cmd_ra;
        Rb <= cmd_rb;
        Rw <= cmd_rw;
      end
      if (state_q == READ) begin
        op_a_q <= doutA;
        op_b_q <= doutB;
      end
      if (state_q == EXEC) begin
        dIN <= result;
        ovf <= result_ovf;
      end
    end
  end

endmodule

// File: tb/tb_reg_add_seq.sv
// Directed bench for reg_add_seq with a behavioural 32x64 register bank.
module tb_reg_add_seq;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_ra, cmd_rb, cmd_rw;
  logic        cmd_sub;
  logic [4:0]  Ra, Rb, Rw;
  logic        WE;
  logic [63:0] dIN;
  logic [63:0] doutA, doutB;
  logic        busy, done, ovf;

  logic [63:0] bank [32];
  logic        ld_en;
  logic [4:0]  ld_a;
  logic [63:0] ld_d;

  int checks = 0;
  int errors = 0;

  reg_add_seq dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rw(cmd_rw), .cmd_sub(cmd_sub),
    .Ra(Ra), .Rb(Rb), .Rw(Rw), .WE(WE), .dIN(dIN),
    .doutA(doutA), .doutB(doutB),
    .busy(busy), .done(done), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign doutA = bank[Ra];
  assign doutB = bank[Rb];

  always @(posedge clk) begin
    if (WE) bank[Rw] <= dIN;
    else if (ld_en) bank[ld_a] <= ld_d;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [4:0] a, input logic [63:0] d);
    @(negedge clk);
    ld_en = 1'b1;
    ld_a  = a;
    ld_d  = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Issues one command from IDLE and checks every cycle up to the return to IDLE.
  task automatic run_cmd(input string tag, input logic [4:0] ra, input logic [4:0] rb,
                         input logic [4:0] rw, input logic sub, input logic [63:0] exp_din,
                         input logic exp_ovf, input logic exp_we, input logic [63:0] exp_bank);
    @(negedge clk);
    check({tag, "_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_ra = ra; cmd_rb = rb; cmd_rw = rw; cmd_sub = sub;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_ra = 5'd9; cmd_rb = 5'd10; cmd_rw = 5'd11; cmd_sub = ~sub;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      check({tag, "_busy"}, busy, 1);
      check({tag, "_ready_busy"}, cmd_ready, 0);
      if (cyc == 0) begin
        check({tag, "_ra"}, Ra, ra);
        check({tag, "_rb"}, Rb, rb);
      end
      if (cyc < 2) begin
        check({tag, "_we_early"}, WE, 0);
        check({tag, "_done_early"}, done, 0);
      end else begin
        check({tag, "_we"}, WE, exp_we);
        check({tag, "_done"}, done, 1);
        check({tag, "_rw"}, Rw, rw);
        check({tag, "_din"}, dIN, exp_din);
        check({tag, "_ovf"}, ovf, exp_ovf);
      end
    end
    @(negedge clk);
    check({tag, "_done_after"}, done, 0);
    check({tag, "_we_after"}, WE, 0);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_din_hold"}, dIN, exp_din);
    check({tag, "_ovf_hold"}, ovf, exp_ovf);
    check({tag, "_bank"}, bank[rw], exp_bank);
  endtask

  // Accepts a command writing rw, then resets during EXEC (stage 2) or WRITE (stage 3).
  task automatic run_reset(input string tag, input int stage, input logic [4:0] rw,
                           input logic [63:0] exp_bank);
    @(negedge clk);
    check({tag, "_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_ra = 5'd1; cmd_rb = 5'd2; cmd_rw = rw; cmd_sub = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (stage) @(negedge clk);
    if (stage == 3) check({tag, "_we_pre"}, WE, 1);
    rst_n = 1'b0;
    #1;
    check({tag, "_we"}, WE, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ready_rst"}, cmd_ready, 0);
    check({tag, "_rw_rst"}, Rw, 0);
    check({tag, "_din_rst"}, dIN, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check({tag, "_ready_rel"}, cmd_ready, 1);
    check({tag, "_busy_rel"}, busy, 0);
    check({tag, "_bank"}, bank[rw], exp_bank);
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_ra = 5'd0; cmd_rb = 5'd0; cmd_rw = 5'd0; cmd_sub = 1'b0;
    ld_en = 1'b0; ld_a = 5'd0; ld_d = 64'd0;
    #2;
    check("rst_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_we", WE, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_din", dIN, 0);
    check("rst_ra", Ra, 0);
    check("rst_rw", Rw, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_ready", cmd_ready, 1);

    load(5'd1, 64'd5);
    load(5'd2, 64'd7);
    load(5'd3, 64'hAAAA);
    load(5'd31, 64'h31);
    run_cmd("add", 5'd1, 5'd2, 5'd3, 1'b0, 64'd12, 1'b0, 1'b1, 64'd12);

    load(5'd1, 64'h7FFF_FFFF_FFFF_FFFF);
    load(5'd2, 64'd1);
    run_cmd("ovf_pos", 5'd1, 5'd2, 5'd4, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b1,
            64'h8000_0000_0000_0000);

    load(5'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    run_cmd("wrap", 5'd1, 5'd2, 5'd4, 1'b0, 64'd0, 1'b0, 1'b1, 64'd0);

    load(5'd1, 64'd3);
    load(5'd2, 64'd5);
`ifdef REG_ADD_SEQ_SUB_EN
    run_cmd("sub", 5'd1, 5'd2, 5'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFE);
`else
    run_cmd("sub_off", 5'd1, 5'd2, 5'd7, 1'b1, 64'd8, 1'b0, 1'b1, 64'd8);
`endif

    run_cmd("xzr", 5'd1, 5'd2, 5'd31, 1'b0, 64'd8, 1'b0, 1'b0, 64'h31);

    load(5'd2, 64'd9);
    run_cmd("same_src", 5'd2, 5'd2, 5'd2, 1'b0, 64'd18, 1'b0, 1'b1, 64'd18);

    // cmd_valid held for 10 cycles: accepted only on cycles 0, 4 and 8.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_ra = 5'd1; cmd_rb = 5'd2; cmd_rw = 5'd8; cmd_sub = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("held_acc%0d", i), cmd_valid & cmd_ready, (i % 4) == 0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("held_bank", bank[8], 64'd21);
    check("held_idle", cmd_ready, 1);

    load(5'd6, 64'h66);
    run_reset("rst_exec", 2, 5'd6, 64'h66);
    run_reset("rst_write", 3, 5'd6, 64'h66);

    load(5'd1, 64'd5);
    load(5'd2, 64'd7);
    run_cmd("post_rst", 5'd1, 5'd2, 5'd3, 1'b0, 64'd12, 1'b0, 1'b1, 64'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
